// File: rtl/ccc_clken_pkg.sv
// Shared types and sizing for the CCC fabric clock-enable generator.
// Holds the lock FSM encoding and the fixed field widths.
package ccc_clken_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_QUAL = 2'd1,
      ST_RUN  = 2'd2
   } lock_state_t;

   localparam int CH_W   = 4;
   localparam int LOSS_W = 8;
   localparam int MAX_CH = 16;

endpackage

// File: rtl/ccc_clken_chan.sv
// One clock-enable channel: divider counter, active/pending divider, CE and pend flag.
// CE is combinational off the counter; writes in RUN wait for the wrap cycle.
// No backpressure: a write is always accepted, a later write overwrites a pending one.
module ccc_clken_chan
   import ccc_clken_pkg::*;
#(
   parameter int DIV_W    = 8,
   parameter int DIV_INIT = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             wr,
   input  logic [DIV_W-1:0] wr_div,
   output logic             ce,
   output logic             cfg_pend
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] d_active;
   logic [DIV_W-1:0] pend_div;
   logic             pend;
   logic             wrap;

   assign wrap = run && (cnt == d_active);
   assign ce   = wrap;
   // A pending value left over at lock loss is committed on the first idle
   // cycle; masking keeps the flag low from the moment RUN is left.
   assign cfg_pend = pend && run;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         d_active <= DIV_W'(DIV_INIT);
         pend_div <= '0;
         pend     <= 1'b0;
      end else if (!run || wrap) begin
         cnt  <= '0;
         pend <= 1'b0;
         if (wr)
            d_active <= wr_div;
         else if (pend)
            d_active <= pend_div;
      end else begin
         cnt <= cnt + DIV_W'(1);
         if (wr) begin
            pend     <= 1'b1;
            pend_div <= wr_div;
         end
      end
   end

endmodule

// File: rtl/ccc_clken_gen.sv
// Fabric clock-enable generator: lock sync + stability filter + N divider channels.
// LOCKED rises LOCK_FILTER+3 edges after lock is sampled; optional LOSS_CNT via CCC_CLKEN_LOSS_CNT_EN.
// No backpressure: configuration writes are single-cycle strobes, out-of-range channels ignored.
module ccc_clken_gen
   import ccc_clken_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int DIV_W       = 8,
   parameter int DIV_INIT    = 0,
   parameter int LOCK_FILTER = 64
) (
   input  logic              FAB_CLK,
   input  logic              M2F_RESET_N,
   input  logic              FAB_LOCK,
   input  logic              CFG_WE,
   input  logic [CH_W-1:0]   CFG_CH,
   input  logic [DIV_W-1:0]  CFG_DIV,
   output logic [N_CH-1:0]   CE,
   output logic              LOCKED,
   output logic [N_CH-1:0]   CFG_PEND
`ifdef CCC_CLKEN_LOSS_CNT_EN
   ,
   output logic [LOSS_W-1:0] LOSS_CNT
`endif
);

   localparam int FILT_W = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;

   logic              lock_m;
   logic              lock_s;
   lock_state_t       state;
   logic [FILT_W-1:0] filt_cnt;
   logic              run;

   always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
      if (!M2F_RESET_N) begin
         lock_m <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         lock_m <= FAB_LOCK;
         lock_s <= lock_m;
      end
   end

   always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
      if (!M2F_RESET_N) begin
         state    <= ST_IDLE;
         filt_cnt <= '0;
         LOCKED   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               filt_cnt <= '0;
               if (lock_s)
                  state <= ST_QUAL;
            end
            ST_QUAL: begin
               if (!lock_s) begin
                  state    <= ST_IDLE;
                  filt_cnt <= '0;
               end else if (filt_cnt == FILT_W'(LOCK_FILTER - 1)) begin
                  state  <= ST_RUN;
                  LOCKED <= 1'b1;
               end else begin
                  filt_cnt <= filt_cnt + FILT_W'(1);
               end
            end
            ST_RUN: begin
               if (!lock_s) begin
                  state  <= ST_IDLE;
                  LOCKED <= 1'b0;
               end
            end
            default: begin
               state    <= ST_IDLE;
               filt_cnt <= '0;
               LOCKED   <= 1'b0;
            end
         endcase
      end
   end

   assign run = (state == ST_RUN);

`ifdef CCC_CLKEN_LOSS_CNT_EN
   always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
      if (!M2F_RESET_N)
         LOSS_CNT <= '0;
      else if (run && !lock_s && (LOSS_CNT != '1))
         LOSS_CNT <= LOSS_CNT + LOSS_W'(1);
   end
`endif

   for (genvar i = 0; i < N_CH; i++) begin : g_chan
      ccc_clken_chan #(
         .DIV_W   (DIV_W),
         .DIV_INIT(DIV_INIT)
      ) u_chan (
         .clk     (FAB_CLK),
         .rst_n   (M2F_RESET_N),
         .run     (run),
         .wr      (CFG_WE && (CFG_CH == CH_W'(i))),
         .wr_div  (CFG_DIV),
         .ce      (CE[i]),
         .cfg_pend(CFG_PEND[i])
      );
   end

endmodule

// File: doc/ccc_clken_gen.md
# ccc_clken_gen

Parametrised fabric clock-enable generator behind the MSS clock conditioning circuit. Takes the CCC lock as an asynchronous input, qualifies it with a stability filter, and drives N independently programmable clock-enable channels from the single fabric clock. Each channel's divider can be reprogrammed at run time without producing a runt period. Downstream fabric logic uses the CE outputs instead of extra global clocks.

## Interface
- N_CH, 4, number of CE channels (1..16)
- DIV_W, 8, divider field width per channel
- DIV_INIT, 0, reset divider value loaded into every channel
- LOCK_FILTER, 64, consecutive cycles of synchronised lock required before release (>=1)
- FAB_CLK  in  1  fabric clock (CCC GLB output)
- M2F_RESET_N  in  1  asynchronous active-low reset
- FAB_LOCK  in  1  CCC lock, asynchronous to FAB_CLK
- CFG_WE  in  1  divider write strobe, one cycle
- CFG_CH  in  4  target channel index
- CFG_DIV  in  DIV_W  new divider value d
- CE  out  N_CH  per-channel clock enables
- LOCKED  out  1  qualified lock
- CFG_PEND  out  N_CH  per-channel flag: a divider write is waiting for its boundary
- LOSS_CNT  out  8  lock-loss count (present only with the macro)

## Operation
- FAB_LOCK passes through a 2-flop synchroniser to produce lock_s.
- FSM states and transitions:
  - IDLE -> QUAL when lock_s=1.
  - QUAL -> IDLE when lock_s=0; the filter counter clears.
  - QUAL -> RUN when the filter counter reaches LOCK_FILTER-1 with lock_s=1.
  - RUN -> IDLE when lock_s=0.
- LOCKED = (state==RUN), registered.
- Channel counters:
  - Held at 0 outside RUN.
  - In RUN, count 0..d_active and wrap.
  - CE[i]=1 in the cycle where cnt==d_active, giving a period of d+1 cycles. d=0 gives CE held high for the whole of RUN.
  - All channels restart at 0 on RUN entry, so they are phase-aligned.
- Divider writes:
  - CFG_WE with CFG_CH >= N_CH is ignored.
  - Outside RUN, the write loads d_active directly.
  - In RUN, the write loads a pending register and sets CFG_PEND[i]. The pending value is applied on the channel's next wrap cycle (CE[i]=1), after which CFG_PEND[i] clears.
  - A write that lands in the wrap cycle itself applies immediately to the next period. CFG_PEND does not set.
  - A second write while pending overwrites the pending value.
  - Loss of lock with a write pending: the pending value is committed to d_active on entry to IDLE and CFG_PEND clears.
- Arithmetic: counters are DIV_W wide, unsigned. d = 2^DIV_W-1 is legal.

## Timing
- Reset values:
  - CE=0, LOCKED=0, CFG_PEND=0, LOSS_CNT=0.
  - Synchroniser flops 0, state IDLE, d_active=DIV_INIT.
- FAB_LOCK rise: LOCKED rises LOCK_FILTER+3 FAB_CLK edges after the first edge that samples FAB_LOCK high (2 sync + LOCK_FILTER filter + 1 state register).
- FAB_LOCK fall: LOCKED and all CE fall 3 edges after the first edge that samples FAB_LOCK low. No partial CE pulse follows.
- First CE[i] after LOCKED rises: in the same cycle when d=0; otherwise d cycles later.
- Reset asserted mid-operation: all outputs return to reset values asynchronously. Pending writes are discarded.

## Configuration
- Macro CCC_CLKEN_LOSS_CNT_EN.
- Defined:
  - LOSS_CNT is present: an 8-bit counter that increments on each RUN->IDLE transition and saturates at 255.
  - It clears only on reset.
- Undefined:
  - The LOSS_CNT port and its logic are absent.
  - All other behaviour is identical.

## Structure
- Package ccc_clken_pkg holds the FSM state enum (IDLE, QUAL, RUN), the width of CFG_CH, the LOSS_CNT width, and the maximum N_CH.
- Sub-module ccc_clken_chan, one per channel, generated N_CH times. It contains the counter, d_active, the pending register, CFG_PEND and CE logic. Its inputs are run, wr, wr_div.
- Synchroniser, lock filter and FSM live in the top level.

## Test plan
- Lock qualify: N_CH=4, LOCK_FILTER=8, FAB_LOCK high from cycle 0 -> LOCKED=1 at edge 11. All CE phase-aligned; ch0 with d=0 gives CE[0]=1 continuously.
- Lock glitch: FAB_LOCK high for 5 cycles, low for 1, then high -> state returns to IDLE and the filter restarts. LOCKED first rises 11 edges after the re-rise is sampled.
- Run-time reprogram: ch1 d=3 running, write d=1 mid-period -> CFG_PEND[1]=1 until the next CE[1]. CE[1] spacing changes from 4 to 2 cycles with no short period.
- Write on wrap cycle: write ch2 d=5 in the cycle CE[2]=1 -> CFG_PEND[2] stays 0 and the next CE[2] comes 6 cycles later. A write with CFG_CH=7 on N_CH=4 -> no channel changes.
- Lock loss: drop FAB_LOCK during RUN -> LOCKED and CE=0 at edge 3. With CCC_CLKEN_LOSS_CNT_EN defined, LOSS_CNT increments by 1; after 300 losses it reads 255.
- Async reset mid-RUN with a write pending -> all outputs 0 immediately. d_active=DIV_INIT after release.
